// File: rtl/bit_byte_mem_if.sv
// rtl/bit_byte_mem_if.sv - request/response bundle for the bit-addressable byte memory
//
// Purpose: groups the CPU-side request and registered response of bit_byte_mem.
// Signals:
//   CS        master->slave  chip select, active-low; request sampled when 0
//   op[2:0]   master->slave  operation code
//   addr      master->slave  bit address {byte index, bit position[2:0]}
//   din[7:0]  master->slave  byte write data
//   din_bit   master->slave  bit write data
//   dout[7:0] slave->master  registered byte result
//   dout_bit  slave->master  registered bit result
//   ack       slave->master  one-cycle completion pulse
//   err       slave->master  one-cycle out-of-range pulse, coincident with ack
interface bit_byte_mem_if #(
  parameter int ADDRWIDTH = 4
);
  logic                   CS;
  logic [2:0]             op;
  logic [ADDRWIDTH+2:0]   addr;
  logic [7:0]             din;
  logic                   din_bit;
  logic [7:0]             dout;
  logic                   dout_bit;
  logic                   ack;
  logic                   err;

  modport master (
    output CS, op, addr, din, din_bit,
    input  dout, dout_bit, ack, err
  );

  modport slave (
    input  CS, op, addr, din, din_bit,
    output dout, dout_bit, ack, err
  );
endinterface

// File: rtl/bit_byte_mem.sv
// rtl/bit_byte_mem.sv - byte RAM with single-cycle atomic bit operations
//
// Purpose: byte-organised RAM whose bits are individually addressable, as in
// the 8051 bit-addressable region. Every request completes at the edge where
// it is sampled; results appear on the bus one cycle later.
// Ports:
//   clk    input  clock, all state changes on the rising edge
//   rst_n  input  synchronous reset, active-low
//   bus    slave  request/response bundle (see bit_byte_mem_if)
module bit_byte_mem #(
  parameter int ADDRWIDTH   = 4,
  parameter int DEPTH       = 2**ADDRWIDTH,
  parameter int RESET_CLEAR = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  bit_byte_mem_if.slave  bus
);

  localparam logic [2:0] OP_RD_BYTE = 3'b000;
  localparam logic [2:0] OP_WR_BYTE = 3'b001;
  localparam logic [2:0] OP_RD_BIT  = 3'b010;
  localparam logic [2:0] OP_WR_BIT  = 3'b011;
  localparam logic [2:0] OP_SET_BIT = 3'b100;
  localparam logic [2:0] OP_CLR_BIT = 3'b101;
  localparam logic [2:0] OP_CPL_BIT = 3'b110;
  localparam logic [2:0] OP_JBC     = 3'b111;

  // One extra bit so DEPTH == 2**ADDRWIDTH is representable.
  localparam logic [ADDRWIDTH:0] DEPTH_W = (ADDRWIDTH+1)'(DEPTH);

  logic [7:0] mem_q [DEPTH];

  logic [7:0] dout_q, dout_d;
  logic       dout_bit_q, dout_bit_d;
  logic       ack_q, ack_d;
  logic       err_q, err_d;

  logic [ADDRWIDTH-1:0] idx;
  logic [2:0]           pos;
  logic                 req;
  logic                 in_range;
  logic [7:0]           old_byte;
  logic                 old_bit;
  logic                 new_bit;
  logic                 rpt_bit;
  logic [7:0]           new_byte;
  logic                 wr_en;

  assign idx = bus.addr[ADDRWIDTH+2:3];
  assign pos = bus.addr[2:0];

  always_comb begin
    req      = ~bus.CS;
    in_range = ({1'b0, idx} < DEPTH_W);
    old_byte = in_range ? mem_q[idx] : 8'h00;
    old_bit  = old_byte[pos];

    // rpt_bit: the bit reported on dout_bit. Read-type ops report the value
    // before modification, write-type ops report the value written.
    new_bit = old_bit;
    rpt_bit = old_bit;
    case (bus.op)
      OP_WR_BIT:  begin new_bit = bus.din_bit; rpt_bit = bus.din_bit; end
      OP_SET_BIT: begin new_bit = 1'b1;        rpt_bit = 1'b1;        end
      OP_CLR_BIT: begin new_bit = 1'b0;        rpt_bit = 1'b0;        end
      OP_CPL_BIT: begin new_bit = ~old_bit;    rpt_bit = old_bit;     end
      OP_JBC:     begin new_bit = 1'b0;        rpt_bit = old_bit;     end
      default:    begin new_bit = old_bit;     rpt_bit = old_bit;     end
    endcase

    new_byte      = old_byte;
    new_byte[pos] = new_bit;
    if (bus.op == OP_WR_BYTE) new_byte = bus.din;

    // Reads leave memory untouched; out-of-range requests never write.
    wr_en = req && in_range && (bus.op != OP_RD_BYTE) && (bus.op != OP_RD_BIT);

    dout_d     = dout_q;
    dout_bit_d = dout_bit_q;
    ack_d      = req;
    err_d      = req && !in_range;
    if (req) begin
      if (!in_range) begin
        dout_d     = 8'h00;
        dout_bit_d = 1'b0;
      end else if (bus.op == OP_RD_BYTE) begin
        dout_d = old_byte;
      end else if (bus.op == OP_WR_BYTE) begin
        dout_d = bus.din;
      end else begin
        dout_d     = new_byte;
        dout_bit_d = rpt_bit;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_q     <= 8'h00;
      dout_bit_q <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      if (RESET_CLEAR != 0) begin
        for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
      end
    end else begin
      dout_q     <= dout_d;
      dout_bit_q <= dout_bit_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      if (wr_en) mem_q[idx] <= new_byte;
    end
  end

  assign bus.dout     = dout_q;
  assign bus.dout_bit = dout_bit_q;
  assign bus.ack      = ack_q;
  assign bus.err      = err_q;

endmodule

// File: doc/bit_byte_mem.md
Name: bit_byte_mem

Overview:
- Parametrised successor to the single-bit memory: a byte-organised RAM whose bits can also be addressed individually, as in the 8051 bit-addressable region (default 16 bytes = 128 bits, 0x20-0x2F).
- Supports byte read/write plus atomic bit read, write, set, clear, complement and test-and-clear (JBC), each in one clock.
- Sits beside the internal RAM/SFR blocks and is driven by the CPU's bit-instruction datapath.

Parameters:
- ADDRWIDTH, 4, byte-index width; bit address is ADDRWIDTH+3 bits.
- DEPTH, 2**ADDRWIDTH, number of implemented bytes (1..2**ADDRWIDTH).
- RESET_CLEAR, 1, when 1 synchronous reset zeroes every byte; when 0 memory contents are untouched by reset.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  synchronous reset, active-low.
- CS  input  1  chip select, active-low; request is sampled only when CS=0.
- op  input  3  operation: 000 byte read, 001 byte write, 010 bit read, 011 bit write, 100 bit set, 101 bit clear, 110 bit complement, 111 test-and-clear.
- addr  input  ADDRWIDTH+3  bit address; byte index = addr[ADDRWIDTH+2:3], bit position = addr[2:0]; byte ops ignore addr[2:0].
- din  input  8  write data for byte write.
- din_bit  input  1  write data for bit write.
- dout  output  8  registered byte result.
- dout_bit  output  1  registered bit result.
- ack  output  1  one-cycle pulse: the request of the previous edge has completed.
- err  output  1  one-cycle pulse, coincident with ack: byte index >= DEPTH.

Behaviour:
- Reset: clk and rst_n are fixed as above. At a rising edge with rst_n=0: dout=0, dout_bit=0, ack=0, err=0. If RESET_CLEAR=1, all DEPTH bytes are set to 0. Reset overrides any simultaneous request, so a request presented during reset is dropped.
- Idle: at an edge with CS=1, no memory change; dout and dout_bit hold; ack=0, err=0.
- Request: at an edge with CS=0 and rst_n=1, the op executes completely at that edge. Results are visible on dout/dout_bit/ack in the following cycle (latency 1). Throughput is one op per cycle, with no busy state.
- Byte read: dout = mem[idx]; dout_bit holds.
- Byte write: mem[idx] = din; dout = din; dout_bit holds.
- Bit ops: old = mem[idx][pos]. The new bit is:
  - bit read: old
  - bit write: din_bit
  - bit set: 1
  - bit clear: 0
  - bit complement: ~old
  - test-and-clear: 0
- Bit-op results: only bit pos of mem[idx] changes. dout = the full byte after modification. dout_bit = old for bit read, complement and test-and-clear; dout_bit = new bit for write, set and clear.
- Read-after-write: back-to-back requests to the same byte see the previous op's result, because memory updates at the earlier edge. No bypass is needed beyond that.
- Out of range (idx >= DEPTH): no memory change; dout=0, dout_bit=0, ack=1, err=1.
- Reset mid-stream: a request accepted at edge N followed by rst_n=0 at edge N+1 commits to memory at N. Its ack is suppressed (ack=0 after N+1). If RESET_CLEAR=1, the committed data is then cleared.
- ack and err are never asserted without a sampled request.

Test Plan:
- Reset with RESET_CLEAR=1 after byte-writing 0xA5 to idx 3 -> byte read of idx 3 returns dout=0x00, ack=1 one cycle after the request.
- Byte write 0x5A to idx 2 (addr=0x10), then byte read next cycle -> dout=0x5A, ack pulses once per request, err=0.
- Bit set on addr 0x13 (idx 2, pos 3) over 0x5A -> dout=0x5A and dout_bit=1 (bit already set). Then bit clear on the same addr -> dout=0x52, dout_bit=0.
- Bit complement on addr 0x10 over 0x52 -> dout_bit=0 (old), dout=0x53. Test-and-clear on the same addr -> dout_bit=1, dout=0x52. A second test-and-clear -> dout_bit=0.
- DEPTH=12, byte write 0xFF to idx 13 -> ack=1, err=1, dout=0. A subsequent read of idx 13 -> err=1, dout=0, and no other byte has changed.
- Request at edge N with rst_n=0 at edge N+1 (RESET_CLEAR=0) -> ack stays 0, and a later read shows the write committed. CS=1 for 3 cycles -> ack=0 and dout holds.
